// File: rtl/rx_data_buffer_if.sv
// Receive-side output stream: head-of-FIFO word, flags and consumer accept.
// The receiver drives the data side; the consumer drives dout_ready.
interface rx_data_buffer_if #(
    parameter int SIZE = 8
);
    logic [SIZE-1:0] dout;
    logic            dout_valid;
    logic            dout_ready;
    logic            ferr;
    logic            perr;
    logic            overrun;

    modport master (
        output dout,
        output dout_valid,
        output ferr,
        output perr,
        output overrun,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  ferr,
        input  perr,
        input  overrun,
        output dout_ready
    );
endinterface

// File: rtl/rx_data_buffer.sv
// Serial frame receiver (start, LSB-first data, optional parity, stop)
// feeding a small FIFO of {data, ferr, perr} entries with sticky overrun.
module rx_data_buffer #(
    parameter int SIZE       = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int DEPTH      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rxc_tick,
    input  logic                rxd,
    input  logic                rxen,
    input  logic                clr_err,
    rx_data_buffer_if.master    bus
);

    localparam int   AW      = $clog2(DEPTH);
    localparam int   CW      = $clog2(SIZE + 1);
    localparam int   EW      = SIZE + 2;
    localparam logic HAS_PAR = (PARITY_EN != 0);
    localparam logic ODD     = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] shift_q, shift_d;
    logic            perr_q, perr_d;
    logic            push;

    logic [EW-1:0]   mem [DEPTH];
    logic [AW:0]     wptr_q, wptr_d;
    logic [AW:0]     rptr_q, rptr_d;
    logic [EW-1:0]   hold_q;
    logic            ovr_q, ovr_d;

    logic            empty;
    logic            full;
    logic            pop;
    logic            wr;
    logic            ovr_set;
    logic [EW-1:0]   head;
    logic [EW-1:0]   out_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
        end
    end

    // Losing RXEN abandons a frame at once, tick or not; STOP always completes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rxc_tick && rxen) begin
                    state_d = START;
                    cnt_d   = '0;
                    perr_d  = 1'b0;
                end
            end
            START: begin
                if (!rxen) begin
                    state_d = IDLE;
                end else if (rxc_tick) begin
                    cnt_d   = '0;
                    state_d = rxd ? IDLE : DATA;
                end
            end
            DATA: begin
                if (!rxen) begin
                    state_d = IDLE;
                end else if (rxc_tick) begin
                    shift_d          = shift_q >> 1;
                    shift_d[SIZE-1]  = rxd;
                    cnt_d            = cnt_q + CW'(1);
                    if (cnt_q == CW'(SIZE - 1)) begin
                        state_d = HAS_PAR ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (!rxen) begin
                    state_d = IDLE;
                end else if (rxc_tick) begin
                    perr_d  = ((^shift_q) ^ rxd) != ODD;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (rxc_tick) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign pop     = !empty && bus.dout_ready;
    assign wr      = push && (!full || pop);
    assign ovr_set = push && full && !pop;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovr_d  = ovr_q;
        if (wr) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (clr_err) begin
            ovr_d = 1'b0;
        end
        if (ovr_set) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr_q[AW-1:0]] <= {shift_q, !rxd, perr_q};
        end
    end

    assign head = mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovr_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovr_q  <= ovr_d;
            if (!empty) begin
                hold_q <= head;
            end
        end
    end

    // Once drained, the outputs keep showing the last head entry.
    assign out_word       = empty ? hold_q : head;
    assign bus.dout       = out_word[EW-1:2];
    assign bus.ferr       = out_word[1];
    assign bus.perr       = out_word[0];
    assign bus.dout_valid = !empty;
    assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_rx_data_buffer.sv
// Directed bench: a no-parity receiver (a) and an even-parity receiver (b)
// sharing the serial line, each with its own bit tick.
module tb_rx_data_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic tick_a;
    logic tick_b;
    logic rxd;
    logic rxen;
    logic clr_err;

    int n_checks = 0;
    int n_fail   = 0;

    rx_data_buffer_if #(.SIZE(8)) ifa ();
    rx_data_buffer_if #(.SIZE(8)) ifb ();

    rx_data_buffer #(
        .SIZE(8), .PARITY_EN(0), .PARITY_ODD(0), .DEPTH(4)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .rxc_tick(tick_a), .rxd(rxd),
        .rxen(rxen), .clr_err(clr_err), .bus(ifa.master)
    );

    rx_data_buffer #(
        .SIZE(8), .PARITY_EN(1), .PARITY_ODD(0), .DEPTH(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .rxc_tick(tick_b), .rxd(rxd),
        .rxen(rxen), .clr_err(clr_err), .bus(ifb.master)
    );

    task automatic tick_bit(input int sel, input logic b);
        @(negedge clk);
        rxd = b;
        if (sel == 0) tick_a = 1'b1;
        else          tick_b = 1'b1;
        @(negedge clk);
        tick_a = 1'b0;
        tick_b = 1'b0;
        rxd    = 1'b1;
    endtask

    // Leading idle-level tick moves IDLE to START; the next tick is the start bit.
    task automatic send_body(input int sel, input logic [7:0] data,
                             input logic par, input logic startb);
        tick_bit(sel, 1'b1);
        tick_bit(sel, startb);
        if (startb) return;
        for (int i = 0; i < 8; i++) tick_bit(sel, data[i]);
        if (sel == 1) tick_bit(sel, par);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] data,
                              input logic par, input logic stop);
        send_body(sel, data, par, 1'b0);
        tick_bit(sel, stop);
    endtask

    task automatic pop(input int sel);
        @(negedge clk);
        if (sel == 0) ifa.dout_ready = 1'b1;
        else          ifb.dout_ready = 1'b1;
        @(negedge clk);
        ifa.dout_ready = 1'b0;
        ifb.dout_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ifa.dout_valid !== 1'b0 || ifa.dout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_out: valid=%b dout=%h want 0/00",
                     ifa.dout_valid, ifa.dout);
        end
        n_checks++;
        if (ifa.ferr !== 1'b0 || ifa.perr !== 1'b0 || ifa.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: ferr=%b perr=%b ovr=%b want 000",
                     ifa.ferr, ifa.perr, ifa.overrun);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        send_body(0, 8'h4A, 1'b0, 1'b0);
        n_checks++;
        if (ifa.dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pre_stop_valid: got %b want 0", ifa.dout_valid);
        end
        tick_bit(0, 1'b1);
        n_checks++;
        if (ifa.dout_valid !== 1'b1 || ifa.dout !== 8'h4A) begin
            n_fail++;
            $display("FAIL basic_word: valid=%b dout=%h want 1/4a",
                     ifa.dout_valid, ifa.dout);
        end
        n_checks++;
        if (ifa.ferr !== 1'b0 || ifa.perr !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_flags: ferr=%b perr=%b want 00", ifa.ferr, ifa.perr);
        end
        pop(0);
        n_checks++;
        if (ifa.dout_valid !== 1'b0 || ifa.dout !== 8'h4A) begin
            n_fail++;
            $display("FAIL basic_hold: valid=%b dout=%h want 0/4a",
                     ifa.dout_valid, ifa.dout);
        end
    endtask

    task automatic test_parity();
        send_frame(1, 8'h07, 1'b0, 1'b1);
        n_checks++;
        if (ifb.dout_valid !== 1'b1 || ifb.dout !== 8'h07 || ifb.perr !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_bad: valid=%b dout=%h perr=%b want 1/07/1",
                     ifb.dout_valid, ifb.dout, ifb.perr);
        end
        pop(1);
        send_frame(1, 8'h07, 1'b1, 1'b1);
        n_checks++;
        if (ifb.dout_valid !== 1'b1 || ifb.dout !== 8'h07 || ifb.perr !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_good: valid=%b dout=%h perr=%b want 1/07/0",
                     ifb.dout_valid, ifb.dout, ifb.perr);
        end
        pop(1);
    endtask

    task automatic test_framing();
        send_frame(0, 8'hFF, 1'b0, 1'b0);
        n_checks++;
        if (ifa.dout_valid !== 1'b1 || ifa.dout !== 8'hFF || ifa.ferr !== 1'b1) begin
            n_fail++;
            $display("FAIL framing: valid=%b dout=%h ferr=%b want 1/ff/1",
                     ifa.dout_valid, ifa.dout, ifa.ferr);
        end
        pop(0);
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 1'b1);
        n_checks++;
        if (ifa.overrun !== 1'b1 || ifa.dout !== 8'h01) begin
            n_fail++;
            $display("FAIL overrun_set: ovr=%b head=%h want 1/01",
                     ifa.overrun, ifa.dout);
        end
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (ifa.dout_valid !== 1'b1 || ifa.dout !== 8'(i)) begin
                n_fail++;
                $display("FAIL overrun_pop%0d: valid=%b dout=%h want 1/%h",
                         i, ifa.dout_valid, ifa.dout, 8'(i));
            end
            pop(0);
        end
        n_checks++;
        if (ifa.dout_valid !== 1'b0 || ifa.overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: valid=%b ovr=%b want 0/1",
                     ifa.dout_valid, ifa.overrun);
        end
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        n_checks++;
        if (ifa.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: got %b want 0", ifa.overrun);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [4];
        exp = '{8'h12, 8'h13, 8'h14, 8'h16};
        for (int i = 1; i <= 4; i++) send_frame(0, 8'h10 + 8'(i), 1'b0, 1'b1);
        send_body(0, 8'h16, 1'b0, 1'b0);
        @(negedge clk);
        rxd = 1'b1;
        tick_a = 1'b1;
        ifa.dout_ready = 1'b1;
        @(negedge clk);
        tick_a = 1'b0;
        ifa.dout_ready = 1'b0;
        n_checks++;
        if (ifa.overrun !== 1'b0 || ifa.dout_valid !== 1'b1 || ifa.dout !== 8'h12) begin
            n_fail++;
            $display("FAIL full_pushpop: ovr=%b valid=%b dout=%h want 0/1/12",
                     ifa.overrun, ifa.dout_valid, ifa.dout);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ifa.dout !== exp[i]) begin
                n_fail++;
                $display("FAIL full_drain%0d: got %h want %h", i, ifa.dout, exp[i]);
            end
            pop(0);
        end
        send_frame(0, 8'h21, 1'b0, 1'b1);
        send_body(0, 8'h22, 1'b0, 1'b0);
        @(negedge clk);
        rxd = 1'b1;
        tick_a = 1'b1;
        ifa.dout_ready = 1'b1;
        @(negedge clk);
        tick_a = 1'b0;
        ifa.dout_ready = 1'b0;
        n_checks++;
        if (ifa.dout_valid !== 1'b1 || ifa.dout !== 8'h22) begin
            n_fail++;
            $display("FAIL partial_pushpop: valid=%b dout=%h want 1/22",
                     ifa.dout_valid, ifa.dout);
        end
        pop(0);
        n_checks++;
        if (ifa.dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_count: valid=%b want 0", ifa.dout_valid);
        end
    endtask

    task automatic test_abort();
        tick_bit(0, 1'b1);
        tick_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) tick_bit(0, 1'b1);
        @(negedge clk);
        rxen = 1'b0;
        repeat (2) @(negedge clk);
        rxen = 1'b1;
        send_frame(0, 8'h33, 1'b0, 1'b1);
        n_checks++;
        if (ifa.dout_valid !== 1'b1 || ifa.dout !== 8'h33 || ifa.ferr !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_next: valid=%b dout=%h ferr=%b want 1/33/0",
                     ifa.dout_valid, ifa.dout, ifa.ferr);
        end
        pop(0);
        n_checks++;
        if (ifa.dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_single: valid=%b want 0", ifa.dout_valid);
        end
        send_body(0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) tick_bit(1, 1'b1);
        n_checks++;
        if (ifa.dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL false_start: valid=%b want 0", ifa.dout_valid);
        end
    endtask

    task automatic test_reset_midframe();
        send_frame(0, 8'h11, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b1);
        tick_bit(0, 1'b1);
        tick_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) tick_bit(0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ifa.dout_valid !== 1'b0 || ifa.dout !== 8'h00 ||
            ifa.ferr !== 1'b0 || ifa.perr !== 1'b0 || ifa.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_out: valid=%b dout=%h ferr=%b perr=%b ovr=%b want all 0",
                     ifa.dout_valid, ifa.dout, ifa.ferr, ifa.perr, ifa.overrun);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_frame(0, 8'h5C, 1'b0, 1'b1);
        n_checks++;
        if (ifa.dout_valid !== 1'b1 || ifa.dout !== 8'h5C) begin
            n_fail++;
            $display("FAIL midreset_frame: valid=%b dout=%h want 1/5c",
                     ifa.dout_valid, ifa.dout);
        end
        pop(0);
        n_checks++;
        if (ifa.dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_only: valid=%b want 0", ifa.dout_valid);
        end
    endtask

    initial begin
        tick_a = 1'b0;
        tick_b = 1'b0;
        rxd = 1'b1;
        rxen = 1'b1;
        clr_err = 1'b0;
        ifa.dout_ready = 1'b0;
        ifb.dout_ready = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_abort();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
